// File: rtl/prog_loader_if.sv
// Byte-link and instruction-memory write bundle for prog_loader.
// master = host side (drives bytes), slave = the loader (drives memory writes/status).
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              cpu_en;
  logic              done;
  logic              error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, word_count, cpu_en, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, word_count, cpu_en, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Packs a big-endian byte stream into 32-bit instruction words and holds the core idle
// until the halt word is stored. Optional trailing XOR checksum: PROG_LOADER_CKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef PROG_LOADER_CKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  state_t            state, state_next;
  logic [1:0]        byte_cnt;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              load_start;
  logic              take_byte;
  logic              is_halt;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        cksum_q;
`endif

  // start is honoured only where no load is in progress.
  assign load_start = bus.start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign take_byte  = (state == S_LOAD) && bus.byte_valid;
  assign is_halt    = (wdata_q == HALT_WORD);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every comb output gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (load_start) state_next = S_LOAD;
      S_LOAD:  if (take_byte && byte_cnt == 2'd3) state_next = S_WRITE;
      S_WRITE: begin
        if (is_halt)
`ifdef PROG_LOADER_CKSUM_EN
          state_next = S_CKSUM;
`else
          state_next = S_DONE;
`endif
        else if (addr_q == LAST_ADDR) state_next = S_ERR;
        else                          state_next = S_LOAD;
      end
`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: if (bus.byte_valid) state_next = (bus.byte_data == cksum_q) ? S_DONE : S_ERR;
`endif
      S_DONE:  if (load_start) state_next = S_LOAD;
      S_ERR:   if (load_start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      count_q  <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      cksum_q  <= '0;
`endif
    end else begin
      if (load_start) begin
        byte_cnt <= '0;
        addr_q   <= '0;
        count_q  <= '0;
`ifdef PROG_LOADER_CKSUM_EN
        cksum_q  <= '0;
`endif
      end
      if (take_byte) begin
        wdata_q  <= {wdata_q[23:0], bus.byte_data};
        byte_cnt <= byte_cnt + 2'd1;
`ifdef PROG_LOADER_CKSUM_EN
        cksum_q  <= cksum_q ^ bus.byte_data;
`endif
      end
      if (state == S_WRITE) begin
        count_q <= count_q + 1'b1;
        // A full memory stops at the last address rather than wrapping.
        if (state_next != S_ERR) addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign bus.mem_we     = (state == S_WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.word_count = count_q;
  assign bus.done       = (state == S_DONE);
  assign bus.cpu_en     = (state == S_DONE);
  assign bus.error      = (state == S_ERR);
`ifdef PROG_LOADER_CKSUM_EN
  assign bus.byte_ready = (state == S_LOAD) || (state == S_CKSUM);
`else
  assign bus.byte_ready = (state == S_LOAD);
`endif

endmodule
